pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Sequences the 3-output system PLL (50/4/25 MHz) from the free-running 50 MHz reference: holds PLL reset,
//  qualifies lock, releases sys_ready to the core only after lock is stable, and re-locks on loss of lock.
//  Bounded retries on lock timeout. Software re-lock via OSD pulse. Sits between board clock input and core reset tree.
// PARAMETERS
//  RST_CYCLES     16      cycles pll_rst is held high per reset attempt (>=1)
//  STABLE_CYCLES  1024    consecutive synced-lock cycles required before sys_ready
//  LOCK_TIMEOUT   500000  max cycles in WAIT_LOCK per attempt (10 ms @ 50 MHz)
//  DROP_CYCLES    4       consecutive synced-unlock cycles in RUN that count as loss of lock
//  MAX_RETRIES    3       timeouts tolerated before FAIL (1..15)
//  CNT_W          20      shared counter width; every count parameter must be < 2**CNT_W
// PORTS
//  refclk         in   1  50 MHz reference clock, free-running, not PLL-derived
//  rst_n          in   1  asynchronous active-low reset
//  req_reset      in   1  synchronous re-lock request (pulse or level), refclk domain
//  pll_locked     in   1  PLL locked, asynchronous to refclk
//  pll_rst        out  1  reset to PLL, active high
//  sys_ready      out  1  high = all PLL clocks valid, core may leave reset
//  fail           out  1  sticky: MAX_RETRIES timeouts exhausted
//  retry_cnt      out  4  timeouts in current lock sequence
//  lost_cnt       out  8  loss-of-lock events since rst_n, saturates at 255
//  state          out  2  0=RESET_HOLD 1=WAIT_LOCK 2=RUN 3=FAIL
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RESET_HOLD, pll_rst=1, sys_ready=0, fail=0, retry_cnt=0, lost_cnt=0, counters=0, sync FFs=0.
//  pll_locked passes a 2-FF synchronizer -> lock_s (2-cycle latency). All outputs are registered.
//  Cycle 0 = first refclk edge after rst_n rises; RESET_HOLD occupies cycles 0..RST_CYCLES-1.
//  RESET_HOLD: pll_rst=1, sys_ready=0; count RST_CYCLES cycles -> WAIT_LOCK (pll_rst=0 from the next cycle), counters cleared.
//  WAIT_LOCK: pll_rst=0. stable_cnt++ while lock_s=1, cleared to 0 when lock_s=0. tmo_cnt++ every cycle.
//   stable_cnt reaches STABLE_CYCLES -> RUN; sys_ready=1 on the cycle RUN is entered; retry_cnt cleared.
//   tmo_cnt reaches LOCK_TIMEOUT first -> retry_cnt++; if new retry_cnt==MAX_RETRIES -> FAIL, else RESET_HOLD.
//   Stability and timeout on the same cycle: stability wins (enter RUN, no retry_cnt increment).
//  RUN: sys_ready=1. drop_cnt++ while lock_s=0, cleared when lock_s=1; shorter glitches are ignored.
//   drop_cnt reaches DROP_CYCLES -> RESET_HOLD; sys_ready=0 on the same edge; lost_cnt++ (saturating).
//  FAIL: pll_rst=1 held, sys_ready=0, fail=1. Leaves only via req_reset or rst_n.
//  req_reset=1 in any state (highest priority over all transitions): next state RESET_HOLD, hold counter restarted,
//   sys_ready=0, fail=0, retry_cnt=0; lost_cnt unchanged. Held high: remain in RESET_HOLD; count restarts every cycle.
//  Counters never wrap: each counter stops at its terminal value and is cleared on every state change.
//  state encoding is fixed as listed under PORTS; no other encodings are reachable.
// TESTING (bench: RST_CYCLES=4 STABLE_CYCLES=8 LOCK_TIMEOUT=64 DROP_CYCLES=2 MAX_RETRIES=2)
//  1 Lock model: pll_locked rises 10 cycles after pll_rst falls. -> pll_rst=1 for cycles 0..3. sys_ready rises
//    20 cycles after pll_rst falls (10 + 2 sync + 8 stable). retry_cnt=0, fail=0.
//  2 pll_locked stuck 0 -> two 64-cycle WAIT_LOCK periods with a 4-cycle RESET_HOLD between; then state=3,
//    fail=1, retry_cnt=2, pll_rst=1. req_reset pulse -> fail=0, retry_cnt=0, full sequence restarts.
//  3 In RUN, pll_locked low 1 cycle -> sys_ready stays 1, lost_cnt=0. Low 3 cycles -> sys_ready=0,
//    lost_cnt=1, pll_rst=1 for 4 cycles, relock, sys_ready=1 again.
//  4 In WAIT_LOCK, pll_locked toggles every 5 cycles -> never stable -> timeout and retry_cnt=1; stable_cnt verified
//    to restart at 0 after every low sample.
//  5 Stability and timeout on the same cycle (lock rises so that stable_cnt hits 8 on cycle 64) -> RUN, retry_cnt unchanged.
//  6 rst_n asserted mid-RUN -> all outputs at reset values asynchronously (before the next edge); 300 loss events
//    -> lost_cnt holds at 255.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, qualifies a synchronized lock indication,
// gates sys_ready to the core, re-locks on loss of lock and gives up after bounded timeouts.
//
// state      | meaning
// RESET_HOLD | pll_rst asserted for RST_CYCLES cycles
// WAIT_LOCK  | pll_rst released; waiting for STABLE_CYCLES of continuous lock, or timeout
// RUN        | lock qualified, sys_ready high, watching for DROP_CYCLES of unlock
// ST_FAIL    | retries exhausted; PLL held in reset until req_reset or rst_n
module pll_lock_sequencer #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned LOCK_TIMEOUT  = 500000,
   parameter int unsigned DROP_CYCLES   = 4,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned CNT_W         = 20
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       req_reset,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_ready,
   output logic       fail,
   output logic [3:0] retry_cnt,
   output logic [7:0] lost_cnt,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      RESET_HOLD = 2'd0,
      WAIT_LOCK  = 2'd1,
      RUN        = 2'd2,
      ST_FAIL    = 2'd3
   } state_t;

   // Each terminal value is the count already reached on the edge that completes the period.
   localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_TC    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DROP_TC   = CNT_W'(DROP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

   state_t           fsm;
   logic             lock_meta;
   logic             lock_s;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] tmo_cnt;
   logic [CNT_W-1:0] stable_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic [3:0]       retry_nxt;

   assign retry_nxt = retry_cnt + 4'd1;
   assign state     = fsm;

   // pll_locked comes from the PLL's own clock domain
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         fsm        <= RESET_HOLD;
         hold_cnt   <= CNT_ZERO;
         tmo_cnt    <= CNT_ZERO;
         stable_cnt <= CNT_ZERO;
         drop_cnt   <= CNT_ZERO;
         pll_rst    <= 1'b1;
         sys_ready  <= 1'b0;
         fail       <= 1'b0;
         retry_cnt  <= 4'd0;
         lost_cnt   <= 8'd0;
      end else if (req_reset) begin
         fsm        <= RESET_HOLD;
         hold_cnt   <= CNT_ZERO;
         tmo_cnt    <= CNT_ZERO;
         stable_cnt <= CNT_ZERO;
         drop_cnt   <= CNT_ZERO;
         pll_rst    <= 1'b1;
         sys_ready  <= 1'b0;
         fail       <= 1'b0;
         retry_cnt  <= 4'd0;
      end else begin
         case (fsm)
            RESET_HOLD: begin
               if (hold_cnt == HOLD_TC) begin
                  fsm        <= WAIT_LOCK;
                  hold_cnt   <= CNT_ZERO;
                  tmo_cnt    <= CNT_ZERO;
                  stable_cnt <= CNT_ZERO;
                  pll_rst    <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + CNT_ONE;
               end
            end

            WAIT_LOCK: begin
               // stability is tested first so it wins a tie with the timeout
               if (lock_s && (stable_cnt == STABLE_TC)) begin
                  fsm        <= RUN;
                  tmo_cnt    <= CNT_ZERO;
                  stable_cnt <= CNT_ZERO;
                  drop_cnt   <= CNT_ZERO;
                  sys_ready  <= 1'b1;
                  retry_cnt  <= 4'd0;
               end else if (tmo_cnt == TMO_TC) begin
                  tmo_cnt    <= CNT_ZERO;
                  stable_cnt <= CNT_ZERO;
                  hold_cnt   <= CNT_ZERO;
                  pll_rst    <= 1'b1;
                  retry_cnt  <= retry_nxt;
                  if (retry_nxt == RETRY_MAX) begin
                     fsm  <= ST_FAIL;
                     fail <= 1'b1;
                  end else begin
                     fsm <= RESET_HOLD;
                  end
               end else begin
                  tmo_cnt    <= tmo_cnt + CNT_ONE;
                  stable_cnt <= lock_s ? (stable_cnt + CNT_ONE) : CNT_ZERO;
               end
            end

            RUN: begin
               if (lock_s) begin
                  drop_cnt <= CNT_ZERO;
               end else if (drop_cnt == DROP_TC) begin
                  fsm       <= RESET_HOLD;
                  drop_cnt  <= CNT_ZERO;
                  hold_cnt  <= CNT_ZERO;
                  pll_rst   <= 1'b1;
                  sys_ready <= 1'b0;
                  if (lost_cnt != 8'hFF) begin
                     lost_cnt <= lost_cnt + 8'd1;
                  end
               end else begin
                  drop_cnt <= drop_cnt + CNT_ONE;
               end
            end

            ST_FAIL: begin
               pll_rst   <= 1'b1;
               sys_ready <= 1'b0;
               fail      <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short parameters; expected values are hand-derived
// cycle offsets from the edge at which pll_rst falls or a request is applied.
module tb_pll_lock_sequencer;

   localparam int RST_C   = 4;
   localparam int STAB_C  = 8;
   localparam int TMO_C   = 64;
   localparam int DROP_C  = 2;
   localparam int RETRY_C = 2;

   logic       refclk     = 1'b0;
   logic       rst_n      = 1'b0;
   logic       req_reset  = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_rst;
   logic       sys_ready;
   logic       fail;
   logic [3:0] retry_cnt;
   logic [7:0] lost_cnt;
   logic [1:0] state;

   int total = 0;
   int bad   = 0;

   pll_lock_sequencer #(
      .RST_CYCLES   (RST_C),
      .STABLE_CYCLES(STAB_C),
      .LOCK_TIMEOUT (TMO_C),
      .DROP_CYCLES  (DROP_C),
      .MAX_RETRIES  (RETRY_C),
      .CNT_W        (20)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .req_reset (req_reset),
      .pll_locked(pll_locked),
      .pll_rst   (pll_rst),
      .sys_ready (sys_ready),
      .fail      (fail),
      .retry_cnt (retry_cnt),
      .lost_cnt  (lost_cnt),
      .state     (state)
   );

   always #5 refclk = ~refclk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge refclk);
   endtask

   function automatic logic toggle_pat(int i);
      return ((i / 5) % 2) == 1;
   endfunction

   // Cycle 0 is the first edge after rst_n rises; pll_rst drops after edge 3.
   task automatic test_reset();
      logic exp;
      rst_n = 1'b0; req_reset = 1'b0; pll_locked = 1'b0;
      repeat (3) tick();
      total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pll_rst got=%b want=1", pll_rst); end
      total++; if (sys_ready !== 1'b0) begin bad++; $display("FAIL reset_sys_ready got=%b want=0", sys_ready); end
      total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b want=0", fail); end
      total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL reset_retry got=%0d want=0", retry_cnt); end
      total++; if (lost_cnt !== 8'd0) begin bad++; $display("FAIL reset_lost got=%0d want=0", lost_cnt); end
      total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         exp = (k < 3);
         total++; if (pll_rst !== exp) begin bad++; $display("FAIL hold_pll_rst edge=%0d got=%b want=%b", k, pll_rst, exp); end
      end
   endtask

   // Entered on the negedge after the edge where pll_rst fell.
   task automatic test_lock();
      logic exp;
      for (int j = 1; j <= 20; j++) begin
         tick();
         exp = (j == 20);
         total++; if (sys_ready !== exp) begin bad++; $display("FAIL lock_sys_ready off=%0d got=%b want=%b", j, sys_ready, exp); end
         total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL lock_pll_rst off=%0d got=%b want=0", j, pll_rst); end
         if (j == 10) pll_locked = 1'b1;
      end
      total++; if (state !== 2'd2) begin bad++; $display("FAIL lock_state got=%0d want=2", state); end
      total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL lock_retry got=%0d want=0", retry_cnt); end
      total++; if (fail !== 1'b0) begin bad++; $display("FAIL lock_fail got=%b want=0", fail); end
   endtask

   task automatic test_drop();
      logic       exp_ready, exp_rst;
      logic [1:0] exp_st;
      logic [7:0] exp_lost;
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      for (int j = 0; j < 6; j++) begin
         tick();
         total++; if (sys_ready !== 1'b1) begin bad++; $display("FAIL glitch_sys_ready got=%b want=1", sys_ready); end
         total++; if (lost_cnt !== 8'd0) begin bad++; $display("FAIL glitch_lost got=%0d want=0", lost_cnt); end
      end
      pll_locked = 1'b0;
      for (int j = 1; j <= 16; j++) begin
         tick();
         exp_ready = (j <= 3) || (j >= 16);
         exp_lost  = (j >= 4) ? 8'd1 : 8'd0;
         exp_rst   = (j >= 4) && (j <= 7);
         exp_st    = (j <= 3) ? 2'd2 : (j <= 7) ? 2'd0 : (j <= 15) ? 2'd1 : 2'd2;
         total++; if (sys_ready !== exp_ready) begin bad++; $display("FAIL drop_sys_ready off=%0d got=%b want=%b", j, sys_ready, exp_ready); end
         total++; if (lost_cnt !== exp_lost) begin bad++; $display("FAIL drop_lost off=%0d got=%0d want=%0d", j, lost_cnt, exp_lost); end
         total++; if (pll_rst !== exp_rst) begin bad++; $display("FAIL drop_pll_rst off=%0d got=%b want=%b", j, pll_rst, exp_rst); end
         total++; if (state !== exp_st) begin bad++; $display("FAIL drop_state off=%0d got=%0d want=%0d", j, state, exp_st); end
         if (j == 3) pll_locked = 1'b1;
      end
   endtask

   task automatic test_timeout_fail();
      logic [1:0] exp_st;
      logic [3:0] exp_retry;
      logic       exp_rst, exp_fail;
      pll_locked = 1'b0;
      req_reset  = 1'b1;
      for (int i = 1; i <= 137; i++) begin
         tick();
         if (i == 1) req_reset = 1'b0;
         exp_st    = (i <= 4) ? 2'd0 : (i <= 68) ? 2'd1 : (i <= 72) ? 2'd0 : (i <= 136) ? 2'd1 : 2'd3;
         exp_retry = (i <= 68) ? 4'd0 : (i <= 136) ? 4'd1 : 4'd2;
         exp_rst   = (exp_st == 2'd0) || (exp_st == 2'd3);
         exp_fail  = (i >= 137);
         total++; if (state !== exp_st) begin bad++; $display("FAIL tmo_state off=%0d got=%0d want=%0d", i, state, exp_st); end
         total++; if (retry_cnt !== exp_retry) begin bad++; $display("FAIL tmo_retry off=%0d got=%0d want=%0d", i, retry_cnt, exp_retry); end
         total++; if (pll_rst !== exp_rst) begin bad++; $display("FAIL tmo_pll_rst off=%0d got=%b want=%b", i, pll_rst, exp_rst); end
         total++; if (fail !== exp_fail) begin bad++; $display("FAIL tmo_fail off=%0d got=%b want=%b", i, fail, exp_fail); end
         total++; if (sys_ready !== 1'b0) begin bad++; $display("FAIL tmo_sys_ready off=%0d got=%b want=0", i, sys_ready); end
      end
      total++; if (lost_cnt !== 8'd1) begin bad++; $display("FAIL tmo_lost_kept got=%0d want=1", lost_cnt); end
      repeat (5) tick();
      total++; if (state !== 2'd3) begin bad++; $display("FAIL fail_sticky got=%0d want=3", state); end
      req_reset = 1'b1;
      tick();
      req_reset = 1'b0;
      total++; if (fail !== 1'b0) begin bad++; $display("FAIL req_fail got=%b want=0", fail); end
      total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL req_retry got=%0d want=0", retry_cnt); end
      total++; if (state !== 2'd0) begin bad++; $display("FAIL req_state got=%0d want=0", state); end
      for (int j = 1; j <= 24; j++) begin
         tick();
         total++; if (pll_rst !== (j < 4)) begin bad++; $display("FAIL restart_pll_rst off=%0d got=%b want=%b", j, pll_rst, (j < 4)); end
         total++; if (sys_ready !== (j == 24)) begin bad++; $display("FAIL restart_sys_ready off=%0d got=%b want=%b", j, sys_ready, (j == 24)); end
         if (j == 14) pll_locked = 1'b1;
      end
   endtask

   // Toggling lock in WAIT_LOCK: lock_s for the edge W+k is the value driven after edge W+k-3.
   task automatic test_toggle();
      logic [19:0] exp_stable;
      logic        dk3;
      pll_locked = 1'b0;
      req_reset  = 1'b1;
      tick();
      req_reset = 1'b0;
      repeat (4) tick();
      total++; if (state !== 2'd1) begin bad++; $display("FAIL toggle_enter got=%0d want=1", state); end
      exp_stable = 20'd0;
      pll_locked = toggle_pat(0);
      for (int k = 1; k <= 64; k++) begin
         tick();
         dk3 = (k >= 3) ? toggle_pat(k - 3) : 1'b0;
         if (k < 64) begin
            exp_stable = dk3 ? exp_stable + 20'd1 : 20'd0;
            total++; if (dut.stable_cnt !== exp_stable) begin bad++; $display("FAIL toggle_stable off=%0d got=%0d want=%0d", k, dut.stable_cnt, exp_stable); end
            total++; if (state !== 2'd1) begin bad++; $display("FAIL toggle_state off=%0d got=%0d want=1", k, state); end
         end else begin
            total++; if (state !== 2'd0) begin bad++; $display("FAIL toggle_tmo_state got=%0d want=0", state); end
            total++; if (retry_cnt !== 4'd1) begin bad++; $display("FAIL toggle_retry got=%0d want=1", retry_cnt); end
         end
         pll_locked = toggle_pat(k);
      end
   endtask

   // Lock driven after edge F+54 makes stable_cnt complete on edge F+64, the timeout edge.
   task automatic test_tie();
      pll_locked = 1'b0;
      req_reset  = 1'b1;
      tick();
      req_reset = 1'b0;
      for (int j = 2; j <= 69; j++) begin
         tick();
         if (j == 5) begin
            total++; if (state !== 2'd1) begin bad++; $display("FAIL tie_enter got=%0d want=1", state); end
         end
         if (j == 68) begin
            total++; if (state !== 2'd1) begin bad++; $display("FAIL tie_before got=%0d want=1", state); end
         end
         if (j == 59) pll_locked = 1'b1;
      end
      total++; if (state !== 2'd2) begin bad++; $display("FAIL tie_state got=%0d want=2", state); end
      total++; if (sys_ready !== 1'b1) begin bad++; $display("FAIL tie_sys_ready got=%b want=1", sys_ready); end
      total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL tie_retry got=%0d want=0", retry_cnt); end
      total++; if (fail !== 1'b0) begin bad++; $display("FAIL tie_fail got=%b want=0", fail); end
   endtask

   task automatic test_async_and_saturate();
      int         n;
      logic [7:0] exp_lost;
      repeat (2) tick();
      total++; if (sys_ready !== 1'b1) begin bad++; $display("FAIL pre_async_ready got=%b want=1", sys_ready); end
      total++; if (lost_cnt !== 8'd1) begin bad++; $display("FAIL pre_async_lost got=%0d want=1", lost_cnt); end
      @(posedge refclk);
      #2 rst_n = 1'b0;
      #1;
      total++; if (sys_ready !== 1'b0) begin bad++; $display("FAIL async_sys_ready got=%b want=0", sys_ready); end
      total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL async_pll_rst got=%b want=1", pll_rst); end
      total++; if (state !== 2'd0) begin bad++; $display("FAIL async_state got=%0d want=0", state); end
      total++; if (lost_cnt !== 8'd0) begin bad++; $display("FAIL async_lost got=%0d want=0", lost_cnt); end
      total++; if (retry_cnt !== 4'd0 || fail !== 1'b0) begin bad++; $display("FAIL async_retry_fail got=%0d/%b want=0/0", retry_cnt, fail); end
      tick();
      rst_n      = 1'b1;
      pll_locked = 1'b1;
      for (int e = 1; e <= 300; e++) begin
         n = 0;
         while (sys_ready !== 1'b1 && n < 200) begin tick(); n++; end
         total++; if (sys_ready !== 1'b1) begin bad++; $display("FAIL sat_wait_ready event=%0d got=%b want=1", e, sys_ready); break; end
         pll_locked = 1'b0;
         repeat (3) tick();
         pll_locked = 1'b1;
         n = 0;
         while (sys_ready !== 1'b0 && n < 20) begin tick(); n++; end
         total++; if (sys_ready !== 1'b0) begin bad++; $display("FAIL sat_wait_drop event=%0d got=%b want=0", e, sys_ready); break; end
         exp_lost = (e > 255) ? 8'd255 : 8'(e);
         total++; if (lost_cnt !== exp_lost) begin bad++; $display("FAIL sat_lost event=%0d got=%0d want=%0d", e, lost_cnt, exp_lost); end
      end
      total++; if (lost_cnt !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d want=255", lost_cnt); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_drop();
      test_timeout_fail();
      test_toggle();
      test_tie();
      test_async_and_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
